// File: rtl/sum_uart_sequencer_if.sv
// ---------------------------------------------------------------------------
// sum_uart_sequencer_if
//   Byte-send handshake between the sum sequencer and the uart_tx block.
//
//   uart_tx_en   : one-cycle strobe, "send uart_tx_data now"
//   uart_tx_data : byte to transmit, held until uart_tx_busy falls
//   uart_tx_busy : high while uart_tx is shifting a frame out
//
//   master : sequencer side (drives en/data, observes busy)
//   slave  : uart_tx side   (observes en/data, drives busy)
// ---------------------------------------------------------------------------
interface sum_uart_sequencer_if;
    logic       uart_tx_en;
    logic [7:0] uart_tx_data;
    logic       uart_tx_busy;

    modport master (output uart_tx_en, output uart_tx_data, input uart_tx_busy);
    modport slave  (input uart_tx_en, input uart_tx_data, output uart_tx_busy);
endinterface

// File: rtl/sum_uart_sequencer.sv
// ---------------------------------------------------------------------------
// sum_uart_sequencer
//   Captures operands A and B from data_input on the falling edge of the
//   (synchronized) active-low save buttons, registers their 5-bit sum, and
//   sends the sum as ASCII decimal followed by CR LF to uart_tx, one byte
//   per uart_tx_en strobe, once per operand pair.
//
//   Build option: define SUMSEQ_ECHO_OPERANDS_EN to prefix the message with
//   "<hexA>+<hexB>=" (8-byte message instead of 4).
//
// Parameters
//   SYNC_STAGES  : synchronizer flops per button (>= 2)
//   BUSY_TIMEOUT : cycles allowed for uart_tx_busy to rise after a strobe
//
// Ports
//   clk          : system clock, rising edge
//   reset_n      : asynchronous active-low reset
//   save_a_n     : operand-A button, active-low, asynchronous
//   save_b_n     : operand-B button, active-low, asynchronous
//   data_input   : operand value sampled at capture
//   uart         : handshake to uart_tx (master modport)
//   op_a, op_b   : captured operands
//   sum          : registered op_a + op_b
//   a_valid      : operand A captured, not yet sent
//   b_valid      : operand B captured, not yet sent
//   seq_busy     : message in progress (FSM not idle)
//   tx_err       : sticky uart_tx_busy timeout flag
// ---------------------------------------------------------------------------
module sum_uart_sequencer #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned BUSY_TIMEOUT = 1024
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        save_a_n,
    input  logic                        save_b_n,
    input  logic [3:0]                  data_input,
    sum_uart_sequencer_if.master        uart,
    output logic [3:0]                  op_a,
    output logic [3:0]                  op_b,
    output logic [4:0]                  sum,
    output logic                        a_valid,
    output logic                        b_valid,
    output logic                        seq_busy,
    output logic                        tx_err
);

`ifdef SUMSEQ_ECHO_OPERANDS_EN
    localparam int unsigned MSG_LEN = 8;
    localparam int unsigned IDX_W   = 3;
`else
    localparam int unsigned MSG_LEN = 4;
    localparam int unsigned IDX_W   = 2;
`endif
    localparam int unsigned TO_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT_HI,
        S_WAIT_LO,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync_a, r_sync_b;
    logic                   r_hist_a, r_hist_b;
    logic [3:0]             r_op_a, r_op_b;
    logic [4:0]             r_sum;
    logic                   r_a_valid, r_b_valid;
    logic                   r_seq_busy, r_tx_err;
    logic                   r_tx_en;
    logic [7:0]             r_tx_data;
    logic [7:0]             r_msg [MSG_LEN];
    logic [IDX_W-1:0]       r_idx;
    logic [TO_W-1:0]        r_to_cnt;

    logic                   w_ev_a, w_ev_b;
    logic [4:0]             w_tens, w_ones;
    logic [7:0]             w_msg [MSG_LEN];

`ifdef SUMSEQ_ECHO_OPERANDS_EN
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        else           return 8'h37 + {4'h0, n};
    endfunction
`endif

    // Button synchronizers; flops idle high so reset never fakes a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_a <= '1;
            r_sync_b <= '1;
            r_hist_a <= 1'b1;
            r_hist_b <= 1'b1;
        end else begin
            r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], save_a_n};
            r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], save_b_n};
            r_hist_a <= r_sync_a[SYNC_STAGES-1];
            r_hist_b <= r_sync_b[SYNC_STAGES-1];
        end
    end

    assign w_ev_a = !r_sync_a[SYNC_STAGES-1] && r_hist_a;
    assign w_ev_b = !r_sync_b[SYNC_STAGES-1] && r_hist_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_sum <= '0;
        else          r_sum <= {1'b0, r_op_a} + {1'b0, r_op_b};
    end

    always_comb begin
        w_tens = r_sum / 5'd10;
        w_ones = r_sum % 5'd10;
`ifdef SUMSEQ_ECHO_OPERANDS_EN
        w_msg[0] = hex_ascii(r_op_a);
        w_msg[1] = 8'h2B;
        w_msg[2] = hex_ascii(r_op_b);
        w_msg[3] = 8'h3D;
        w_msg[4] = 8'h30 + {3'b000, w_tens};
        w_msg[5] = 8'h30 + {3'b000, w_ones};
        w_msg[6] = 8'h0D;
        w_msg[7] = 8'h0A;
`else
        w_msg[0] = 8'h30 + {3'b000, w_tens};
        w_msg[1] = 8'h30 + {3'b000, w_ones};
        w_msg[2] = 8'h0D;
        w_msg[3] = 8'h0A;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_a_valid  <= 1'b0;
            r_b_valid  <= 1'b0;
            r_seq_busy <= 1'b0;
            r_tx_err   <= 1'b0;
            r_tx_en    <= 1'b0;
            r_tx_data  <= '0;
            r_msg      <= '{default: '0};
            r_idx      <= '0;
            r_to_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_a_valid && r_b_valid) begin
                        r_state    <= S_LOAD;
                        r_seq_busy <= 1'b1;
                    end else if (w_ev_a) begin
                        // A wins a same-cycle tie; the B event is dropped.
                        r_op_a    <= data_input;
                        r_a_valid <= 1'b1;
                    end else if (w_ev_b) begin
                        r_op_b    <= data_input;
                        r_b_valid <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_msg <= w_msg;
                    r_idx <= '0;
                    // First byte issues straight from LOAD when the UART is
                    // free, so the strobe lands two cycles after both valids.
                    if (!uart.uart_tx_busy) begin
                        r_tx_en   <= 1'b1;
                        r_tx_data <= w_msg[0];
                        r_to_cnt  <= '0;
                        r_state   <= S_WAIT_HI;
                    end else begin
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (!uart.uart_tx_busy) begin
                        r_tx_en   <= 1'b1;
                        r_tx_data <= r_msg[r_idx];
                        r_to_cnt  <= '0;
                        r_state   <= S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    r_tx_en <= 1'b0;
                    if (uart.uart_tx_busy) begin
                        r_state <= S_WAIT_LO;
                    end else if (r_to_cnt == TO_W'(BUSY_TIMEOUT - 1)) begin
                        r_tx_err   <= 1'b1;
                        r_a_valid  <= 1'b0;
                        r_b_valid  <= 1'b0;
                        r_seq_busy <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                S_WAIT_LO: begin
                    if (!uart.uart_tx_busy) begin
                        if (r_idx == IDX_W'(MSG_LEN - 1)) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_SEND;
                        end
                    end
                end
                S_DONE: begin
                    r_a_valid  <= 1'b0;
                    r_b_valid  <= 1'b0;
                    r_seq_busy <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_tx_en    <= 1'b0;
                    r_seq_busy <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign uart.uart_tx_en   = r_tx_en;
    assign uart.uart_tx_data = r_tx_data;
    assign op_a              = r_op_a;
    assign op_b              = r_op_b;
    assign sum               = r_sum;
    assign a_valid           = r_a_valid;
    assign b_valid           = r_b_valid;
    assign seq_busy          = r_seq_busy;
    assign tx_err            = r_tx_err;

endmodule

// File: doc/sum_uart_sequencer.md
# sum_uart_sequencer

Control sequencer for the operand-latch / 4-bit adder / UART transmit datapath. It captures operands A and B from the 4-bit `data_input` bus on the active-low save buttons and forms the 5-bit sum. It formats the sum as ASCII decimal and feeds it to `uart_tx` one byte at a time through that block's `uart_tx_en`/`uart_tx_busy` handshake, so each operand pair produces exactly one message. It replaces the free-running `uart_tx_en = 1` tie-off at the top level.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops on each save button (≥2).
- `BUSY_TIMEOUT`, 1024: cycles to wait for `uart_tx_busy` to rise after an enable pulse.
- `clk` in 1: system clock; all logic rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `save_a_n` in 1: operand-A button, active-low, asynchronous to `clk`.
- `save_b_n` in 1: operand-B button, active-low, asynchronous to `clk`.
- `data_input` in 4: operand value sampled at capture.
- `uart_tx_busy` in 1: busy flag from `uart_tx`.
- `uart_tx_en` out 1: one-cycle byte-send strobe to `uart_tx`.
- `uart_tx_data` out 8: byte to `uart_tx`.
- `op_a`, `op_b` out 4 each: captured operands.
- `sum` out 5: `op_a + op_b`, zero-extended, registered.
- `a_valid`, `b_valid` out 1 each: operand captured, not yet sent.
- `seq_busy` out 1: message transmission in progress.
- `tx_err` out 1: sticky timeout flag.

## Operation
- Reset values: all outputs 0.
- Each button passes through `SYNC_STAGES` flops plus one history flop. A capture event is synchronized value 0 with history 1 (falling edge).
- In IDLE:
  - A event: `op_a <= data_input`, `a_valid <= 1`.
  - B event: likewise for `op_b` and `b_valid`.
  - A repeat press overwrites the operand.
  - A and B events in the same cycle: only A is captured; the B event is dropped.
- `sum` updates one cycle after any operand change.
- Transmission start:
  - When `a_valid & b_valid` are both set in IDLE, the FSM moves to LOAD on the next edge.
  - LOAD latches the message bytes from `sum`:
    - tens = `'0' + sum/10`
    - ones = `'0' + sum%10`
    - then 0x0D, 0x0A.
  - The leading zero is always sent. Sum range is 0..30.
- FSM states: IDLE → LOAD → SEND → WAIT_HI → WAIT_LO → (SEND for the next byte | DONE) → IDLE.
  - SEND: wait until `uart_tx_busy` = 0, then assert `uart_tx_en` for exactly one cycle with `uart_tx_data` = current byte.
  - WAIT_HI: wait for `uart_tx_busy` = 1. If `BUSY_TIMEOUT` cycles elapse first, set `tx_err`, clear the valid flags, and go to IDLE.
  - WAIT_LO: wait for `uart_tx_busy` = 0, then advance the byte index.
  - DONE: clear `a_valid`/`b_valid` (operand values are retained), then go to IDLE.
- `seq_busy` = 1 in every state except IDLE.
- Button events outside IDLE are ignored and not queued.
- `tx_err` clears only on reset.
- Asserting `reset_n` mid-message aborts it immediately. `uart_tx_en` drops asynchronously and no further bytes are issued.

## Timing
- Capture latency: falling edge of a synchronized button to operand register update is `SYNC_STAGES`+1 cycles (at most one extra cycle for metastability resolution).
- Start latency: from the cycle both valids are 1:
  - LOAD is 1 cycle later.
  - The first `uart_tx_en` comes 2 cycles later if `uart_tx_busy` = 0.
- `uart_tx_en` is high for exactly 1 cycle per byte and is never asserted while `uart_tx_busy` = 1.
- `uart_tx_data` is stable from the `uart_tx_en` cycle until `uart_tx_busy` falls.
- Bytes are sent in order with no gaps beyond the handshake. Minimum per-byte overhead is 3 cycles plus the UART frame time.
- Timeout counter:
  - Clears on entry to WAIT_HI.
  - Trips when the count equals `BUSY_TIMEOUT`-1 with `uart_tx_busy` still 0.

## Configuration
- `SUMSEQ_ECHO_OPERANDS_EN` defined: the message is 8 bytes.
  - Format: hex(A), '+', hex(B), '=', tens, ones, 0x0D, 0x0A.
  - Hex digits are uppercase ('0'-'9', 'A'-'F').
  - The byte index is 3 bits.
- `SUMSEQ_ECHO_OPERANDS_EN` undefined: the message is the 4 bytes tens, ones, 0x0D, 0x0A. The byte index is 2 bits.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then idle 50 cycles → all outputs 0 and no `uart_tx_en` pulses.
- Press A with `data_input`=3, then B with 4; UART model holds busy for 20 cycles per byte.
  - Base build: bytes 0x30, 0x37, 0x0D, 0x0A, `sum`=7.
  - Echo build: "3+4=07\r\n".
- A=F, B=F → `sum`=30 (5'b11110), bytes 0x33, 0x30, 0x0D, 0x0A. `a_valid`/`b_valid` are 0 after DONE.
- Drop `save_a_n` and `save_b_n` in the same cycle with `data_input`=5 → `op_a`=5, `a_valid`=1, `b_valid`=0, no transmission.
- UART model never raises busy, `BUSY_TIMEOUT`=16 → `tx_err`=1 exactly 16 cycles after the first `uart_tx_en`, FSM back in IDLE, valids cleared. A later press pair is still sent normally and `tx_err` stays 1.
- Pulse `reset_n` low during the second byte → `uart_tx_en`=0, `seq_busy`=0, valids=0 immediately, and no further bytes are issued after release.
